// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
//   Shared definitions for the pulse-train scheduler: state encoding and the
//   default widths of the period/width (PW) and pulse-count (CW) fields.
// -----------------------------------------------------------------------------
package pulse_pkg;

  localparam int PW_DEF = 16;
  localparam int CW_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    LOW  = ST_LOW,
    FIN  = ST_FIN
  } state_t;

endpackage

// File: rtl/pulse_train_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_train_ctrl
//   Programmable pulse-train scheduler. On an accepted start it drives pulse
//   high for cfg_width cycles and low for cfg_period-cfg_width cycles, repeated
//   cfg_count times, then strobes done for one cycle.
//
// Ports
//   clk         in  1   rising-edge clock
//   rst         in  1   asynchronous active-high reset
//   start       in  1   request a train (accepted only in IDLE)
//   stop        in  1   abort; overrides everything except reset
//   cfg_period  in  PW  cycles per pulse period (sampled on accept)
//   cfg_width   in  PW  pulse high cycles (sampled on accept)
//   cfg_count   in  CW  number of pulses (sampled on accept)
//   pulse       out 1   registered pulse output
//   busy        out 1   high during HIGH and LOW phases
//   done        out 1   one-cycle strobe after the final period
//   err         out 1   one-cycle strobe when start is rejected for bad config
// -----------------------------------------------------------------------------
module pulse_train_ctrl
  import pulse_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [PW-1:0] cfg_period,
  input  logic [PW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_count,
  output logic          pulse,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [PW-1:0] ONE_P = PW'(1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t        state;
  logic [PW-1:0] period_q;
  logic [PW-1:0] width_q;
  // Cycles left in the current phase after this one; 0 means last cycle.
  logic [PW-1:0] ph_cnt;
  // Pulses still to complete, including the one in progress.
  logic [CW-1:0] pulse_cnt;

  function automatic logic cfg_valid(input logic [PW-1:0] period,
                                     input logic [PW-1:0] width,
                                     input logic [CW-1:0] count);
    return (width != '0) && (width < period) && (count != '0);
  endfunction

  // Outputs are assigned alongside the state transition, so each output flop
  // reflects the state being entered and no input reaches an output
  // combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, counters and config included, is reset so an
      // aborted train leaves no stale config behind.
      state     <= IDLE;
      period_q  <= '0;
      width_q   <= '0;
      ph_cnt    <= '0;
      pulse_cnt <= '0;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state and counters.
      err <= 1'b0;
      if (stop) begin
        state <= IDLE;
        pulse <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_valid(cfg_period, cfg_width, cfg_count)) begin
                period_q  <= cfg_period;
                width_q   <= cfg_width;
                ph_cnt    <= cfg_width - ONE_P;
                pulse_cnt <= cfg_count;
                state     <= HIGH;
                pulse     <= 1'b1;
                busy      <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end

          HIGH: begin
            if (ph_cnt == '0) begin
              state  <= LOW;
              pulse  <= 1'b0;
              ph_cnt <= period_q - width_q - ONE_P;
            end else begin
              ph_cnt <= ph_cnt - ONE_P;
            end
          end

          LOW: begin
            if (ph_cnt == '0) begin
              pulse_cnt <= pulse_cnt - ONE_C;
              if (pulse_cnt != ONE_C) begin
                state  <= HIGH;
                pulse  <= 1'b1;
                ph_cnt <= width_q - ONE_P;
              end else begin
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              ph_cnt <= ph_cnt - ONE_P;
            end
          end

          FIN: begin
            // A start here is deliberately ignored; it is accepted next cycle.
            state <= IDLE;
            done  <= 1'b0;
          end

          default: begin
            state <= IDLE;
            pulse <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  // Human-readable state name for waveform and debug use.
  function automatic string state_name(input state_t s);
    return s.name();
  endfunction
`endif

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_ctrl
//   Scoreboard bench for pulse_train_ctrl. The driver applies stimulus and,
//   at each rising edge, a position-based reference model predicts the output
//   vector {pulse,busy,done,err} for the coming cycle and pushes it into a
//   queue. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_pulse_train_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] cfg_period;
  logic [15:0] cfg_width;
  logic [7:0]  cfg_count;
  logic        pulse;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  pulse_train_ctrl #(.PW(16), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_count  (cfg_count),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];

  // Reference model: m_pos is the 1-based cycle position within the current
  // train (0 = idle). Positions 1..N*P are the pulse periods, N*P+1 is the
  // single done cycle.
  int m_pos = 0;
  int m_p   = 0;
  int m_w   = 0;
  int m_n   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic sp, input int p,
                            input int w, input int n);
    logic       e_err;
    logic [3:0] e;
    e_err = 1'b0;
    if (m_pos != 0) begin
      if (sp)                        m_pos = 0;
      else if (m_pos == m_n*m_p + 1) m_pos = 0;
      else                           m_pos++;
    end else if (s && !sp) begin
      if (w != 0 && w < p && n != 0) begin
        m_p = p; m_w = w; m_n = n; m_pos = 1;
      end else begin
        e_err = 1'b1;
      end
    end
    if (m_pos == 0)
      e = {3'b000, e_err};
    else if (m_pos <= m_n*m_p)
      e = {(((m_pos - 1) % m_p) < m_w), 1'b1, 1'b0, 1'b0};
    else
      e = 4'b0010;
    exp_q.push_back(e);
  endtask

  // One clock: inputs set by the caller are sampled at the edge, then the
  // config bus is scrambled since it is don't-care outside acceptance.
  task automatic step(input logic s, input logic sp);
    start = s;
    stop  = sp;
    @(posedge clk);
    if (!rst) model_edge(s, sp, int'(cfg_period), int'(cfg_width), int'(cfg_count));
    #1;
    start      = 1'b0;
    stop       = 1'b0;
    cfg_period = 16'($urandom);
    cfg_width  = 16'($urandom);
    cfg_count  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic set_cfg(input int p, input int w, input int n);
    cfg_period = 16'(p);
    cfg_width  = 16'(w);
    cfg_count  = 8'(n);
  endtask

  task automatic go(input int p, input int w, input int n);
    set_cfg(p, w, n);
    step(1'b1, 1'b0);
  endtask

  // Called just after a step; asserts reset between edges and checks that
  // the outputs clear without waiting for a clock.
  task automatic async_reset();
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_pos = 0;
    #1;
    check("async_reset_outputs", {28'd0, pulse, busy, done, err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs{pulse,busy,done,err}", {28'd0, pulse, busy, done, err},
            {28'd0, e});
    end
  end

  initial begin
    int p;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    set_cfg(0, 0, 0);
    #1;
    check("reset_outputs", {28'd0, pulse, busy, done, err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic train: pulses in cycles 1 and 5, done in cycle 9.
    go(4, 1, 2);
    idle(10);

    // Rejected configs: zero width, width == period, zero count.
    go(4, 0, 2);
    idle(2);
    go(3, 3, 2);
    idle(2);
    go(5, 2, 0);
    idle(2);

    // Stop during the third high phase, then immediate restart.
    go(6, 3, 5);
    idle(13);
    step(1'b0, 1'b1);
    go(2, 1, 1);
    idle(4);

    // Start and stop together are not accepted.
    set_cfg(4, 2, 3);
    step(1'b1, 1'b1);
    idle(2);

    // Start held high for the whole train, including the done cycle.
    go(3, 1, 3);
    repeat (3*3 + 1) begin
      set_cfg(5, 2, 2);
      step(1'b1, 1'b0);
    end
    idle(3);

    // Minimum low phase (width = period-1).
    go(5, 4, 2);
    idle(12);

    // Asynchronous reset in the middle of a low phase.
    go(10, 2, 3);
    idle(4);
    async_reset();
    go(2, 1, 1);
    idle(4);

    // Maximum pulse count: done in cycle 511.
    go(2, 1, 255);
    idle(515);

    // Random mix of starts, stops and configs, valid and invalid.
    repeat (3000) begin
      p = int'($urandom_range(1, 10));
      set_cfg(p, int'($urandom_range(0, p)), int'($urandom_range(0, 4)));
      step(($urandom % 6) == 0, ($urandom % 40) == 0);
    end
    idle(60);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
